merge_pass_scheduler: RTL and testbench

// Sequences the phase-2 4-way merge tree across multiple passes over DRAM-resident sorted runs.

---
 rtl/merge_pass_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_merge_pass_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_pass_scheduler.sv
// Multi-pass 4-way merge command sequencer over ping-pong DRAM regions.
// Define MERGE_SCHED_PERF_EN to add busy-cycle and merged-group counters.
`timescale 1ns/1ps
module merge_pass_scheduler #(
  parameter int ADDR_WIDTH   = 64,
  parameter int LEN_WIDTH    = 32,
  parameter int BUNDLE_BYTES = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src_base,
  input  logic [ADDR_WIDTH-1:0] i_dst_base,
  input  logic [LEN_WIDTH-1:0]  i_total_len,
  input  logic [LEN_WIDTH-1:0]  i_init_run_len,
  output logic                  o_rd_cmd_vld,
  input  logic                  i_rd_cmd_rdy,
  output logic [1:0]            o_rd_cmd_leaf,
  output logic [ADDR_WIDTH-1:0] o_rd_cmd_addr,
  output logic [LEN_WIDTH-1:0]  o_rd_cmd_len,
  output logic                  o_wr_cmd_vld,
  input  logic                  i_wr_cmd_rdy,
  output logic [ADDR_WIDTH-1:0] o_wr_cmd_addr,
  output logic [LEN_WIDTH-1:0]  o_wr_cmd_len,
  input  logic                  i_root_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_result_base,
`ifdef MERGE_SCHED_PERF_EN
  output logic [31:0]           o_cycle_cnt,
  output logic [31:0]           o_group_cnt,
`endif
  output logic [7:0]            o_pass_cnt
);

  localparam int SHIFT = $clog2(BUNDLE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_RD_ISSUE  = 3'd2,
    S_WR_ISSUE  = 3'd3,
    S_WAIT_LAST = 3'd4,
    S_FIN       = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]  r_total;
  logic [LEN_WIDTH-1:0]  r_run_len;
  logic [LEN_WIDTH-1:0]  r_offset;
  logic [LEN_WIDTH-1:0]  r_group_start;
  logic [1:0]            r_leaf;

  logic                  w_start_acc;
  logic                  w_last_acc;
  logic                  w_rd_hs;
  logic                  w_wr_hs;
  logic [LEN_WIDTH-1:0]  w_off_nxt;
  logic [LEN_WIDTH-1:0]  w_len_nxt;
  logic [LEN_WIDTH+1:0]  w_run_x4;
  logic [LEN_WIDTH-1:0]  w_run_nxt;

  // Leaf run length: a full run, the tail remainder, or empty once past the end.
  function automatic logic [LEN_WIDTH-1:0] f_rd_len(input logic [LEN_WIDTH-1:0] off,
                                                    input logic [LEN_WIDTH-1:0] run,
                                                    input logic [LEN_WIDTH-1:0] total);
    logic [LEN_WIDTH-1:0] rem;
    logic [LEN_WIDTH-1:0] len;
    rem = total - off;
    if (off >= total) len = {LEN_WIDTH{1'b0}};
    else if (run < rem) len = run;
    else len = rem;
    return len;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [ADDR_WIDTH-1:0] base,
                                                   input logic [LEN_WIDTH-1:0]  off);
    logic [ADDR_WIDTH-1:0] off_ext;
    off_ext = ADDR_WIDTH'(off);
    return base + (off_ext << SHIFT);
  endfunction

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_last_acc  = (r_state == S_WAIT_LAST) && i_root_last;
  assign w_rd_hs     = (r_state == S_RD_ISSUE) && o_rd_cmd_vld && i_rd_cmd_rdy;
  assign w_wr_hs     = (r_state == S_WR_ISSUE) && o_wr_cmd_vld && i_wr_cmd_rdy;
  assign w_off_nxt   = r_offset + o_rd_cmd_len;
  assign w_len_nxt   = f_rd_len(w_off_nxt, r_run_len, r_total);
  // Two extra bits keep run_len*4 exact before saturating at the job size.
  assign w_run_x4    = {r_run_len, 2'b00};
  assign w_run_nxt   = (w_run_x4 >= {2'b00, r_total}) ? r_total : w_run_x4[LEN_WIDTH-1:0];

  // Pass / group / leaf sequencing FSM with registered command and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_src         <= {ADDR_WIDTH{1'b0}};
      r_dst         <= {ADDR_WIDTH{1'b0}};
      r_total       <= {LEN_WIDTH{1'b0}};
      r_run_len     <= {LEN_WIDTH{1'b0}};
      r_offset      <= {LEN_WIDTH{1'b0}};
      r_group_start <= {LEN_WIDTH{1'b0}};
      r_leaf        <= 2'd0;
      o_rd_cmd_vld  <= 1'b0;
      o_rd_cmd_leaf <= 2'd0;
      o_rd_cmd_addr <= {ADDR_WIDTH{1'b0}};
      o_rd_cmd_len  <= {LEN_WIDTH{1'b0}};
      o_wr_cmd_vld  <= 1'b0;
      o_wr_cmd_addr <= {ADDR_WIDTH{1'b0}};
      o_wr_cmd_len  <= {LEN_WIDTH{1'b0}};
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result_base <= {ADDR_WIDTH{1'b0}};
      o_pass_cnt    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (w_start_acc) begin
            r_src      <= i_src_base;
            r_dst      <= i_dst_base;
            r_total    <= i_total_len;
            r_run_len  <= i_init_run_len;
            o_pass_cnt <= 8'd0;
            o_busy     <= 1'b1;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_run_len >= r_total) begin
            o_done        <= 1'b1;
            o_result_base <= r_src;
            o_busy        <= 1'b0;
            r_state       <= S_FIN;
          end else begin
            r_offset      <= {LEN_WIDTH{1'b0}};
            r_group_start <= {LEN_WIDTH{1'b0}};
            r_leaf        <= 2'd0;
            o_rd_cmd_vld  <= 1'b1;
            o_rd_cmd_leaf <= 2'd0;
            o_rd_cmd_addr <= r_src;
            o_rd_cmd_len  <= f_rd_len({LEN_WIDTH{1'b0}}, r_run_len, r_total);
            r_state       <= S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          if (w_rd_hs) begin
            r_offset <= w_off_nxt;
            if (r_leaf == 2'd3) begin
              o_rd_cmd_vld  <= 1'b0;
              o_wr_cmd_vld  <= 1'b1;
              o_wr_cmd_addr <= f_addr(r_dst, r_group_start);
              o_wr_cmd_len  <= w_off_nxt - r_group_start;
              r_state       <= S_WR_ISSUE;
            end else begin
              r_leaf        <= r_leaf + 2'd1;
              o_rd_cmd_leaf <= r_leaf + 2'd1;
              o_rd_cmd_addr <= f_addr(r_src, w_off_nxt);
              o_rd_cmd_len  <= w_len_nxt;
            end
          end
        end
        S_WR_ISSUE: begin
          if (w_wr_hs) begin
            o_wr_cmd_vld <= 1'b0;
            r_state      <= S_WAIT_LAST;
          end
        end
        S_WAIT_LAST: begin
          if (w_last_acc) begin
            if (r_offset < r_total) begin
              r_group_start <= r_offset;
              r_leaf        <= 2'd0;
              o_rd_cmd_vld  <= 1'b1;
              o_rd_cmd_leaf <= 2'd0;
              o_rd_cmd_addr <= f_addr(r_src, r_offset);
              o_rd_cmd_len  <= f_rd_len(r_offset, r_run_len, r_total);
              r_state       <= S_RD_ISSUE;
            end else begin
              r_src      <= r_dst;
              r_dst      <= r_src;
              o_pass_cnt <= o_pass_cnt + 8'd1;
              r_run_len  <= w_run_nxt;
              r_state    <= S_SETUP;
            end
          end
        end
        S_FIN: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MERGE_SCHED_PERF_EN
  // Busy-cycle (saturating) and merged-group counters, cleared per accepted job.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_acc) begin
      o_cycle_cnt <= 32'd0;
      o_group_cnt <= 32'd0;
    end else begin
      if (o_busy && (o_cycle_cnt != 32'hFFFF_FFFF)) o_cycle_cnt <= o_cycle_cnt + 32'd1;
      if (w_last_acc) o_group_cnt <= o_group_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_merge_pass_scheduler.sv
// Scoreboard bench for merge_pass_scheduler: directed jobs, queued expectations, negedge monitor.
`timescale 1ns/1ps
module tb_merge_pass_scheduler;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [63:0] i_src_base;
  logic [63:0] i_dst_base;
  logic [31:0] i_total_len;
  logic [31:0] i_init_run_len;
  logic        o_rd_cmd_vld;
  logic        i_rd_cmd_rdy;
  logic [1:0]  o_rd_cmd_leaf;
  logic [63:0] o_rd_cmd_addr;
  logic [31:0] o_rd_cmd_len;
  logic        o_wr_cmd_vld;
  logic        i_wr_cmd_rdy;
  logic [63:0] o_wr_cmd_addr;
  logic [31:0] o_wr_cmd_len;
  logic        i_root_last;
  logic        root_a;
  logic        root_b;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_result_base;
  logic [7:0]  o_pass_cnt;
`ifdef MERGE_SCHED_PERF_EN
  logic [31:0] o_cycle_cnt;
  logic [31:0] o_group_cnt;
`endif

  typedef struct packed { logic [1:0] leaf; logic [63:0] addr; logic [31:0] len; } rd_t;
  typedef struct packed { logic [63:0] addr; logic [31:0] len; } wr_t;
  typedef struct packed { logic [63:0] base; logic [7:0] pass; } dn_t;

  rd_t exp_rd[$];
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  stall_cyc = 0;
  event wr_acc;

  always #5 clk = ~clk;
  assign i_root_last = root_a | root_b;

  merge_pass_scheduler dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_src_base(i_src_base), .i_dst_base(i_dst_base),
    .i_total_len(i_total_len), .i_init_run_len(i_init_run_len),
    .o_rd_cmd_vld(o_rd_cmd_vld), .i_rd_cmd_rdy(i_rd_cmd_rdy),
    .o_rd_cmd_leaf(o_rd_cmd_leaf), .o_rd_cmd_addr(o_rd_cmd_addr), .o_rd_cmd_len(o_rd_cmd_len),
    .o_wr_cmd_vld(o_wr_cmd_vld), .i_wr_cmd_rdy(i_wr_cmd_rdy),
    .o_wr_cmd_addr(o_wr_cmd_addr), .o_wr_cmd_len(o_wr_cmd_len),
    .i_root_last(i_root_last), .o_busy(o_busy), .o_done(o_done),
    .o_result_base(o_result_base),
`ifdef MERGE_SCHED_PERF_EN
    .o_cycle_cnt(o_cycle_cnt), .o_group_cnt(o_group_cnt),
`endif
    .o_pass_cnt(o_pass_cnt)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_rd(input logic [1:0] l, input logic [63:0] a, input logic [31:0] n);
    rd_t e;
    e.leaf = l; e.addr = a; e.len = n;
    exp_rd.push_back(e);
  endtask

  task automatic push_wr(input logic [63:0] a, input logic [31:0] n);
    wr_t e;
    e.addr = a; e.len = n;
    exp_wr.push_back(e);
  endtask

  task automatic push_dn(input logic [63:0] b, input logic [7:0] p);
    dn_t e;
    e.base = b; e.pass = p;
    exp_dn.push_back(e);
  endtask

  // Monitor: pops expectations on each handshake / done and checks stall stability.
  initial begin : monitor
    rd_t cur_rd, prv_rd, e_rd;
    wr_t cur_wr, prv_wr, e_wr;
    dn_t e_dn;
    logic pend_rd, pend_wr;
    pend_rd = 1'b0;
    pend_wr = 1'b0;
    prv_rd = '0;
    prv_wr = '0;
    forever begin
      @(negedge clk);
      cur_rd = {o_rd_cmd_leaf, o_rd_cmd_addr, o_rd_cmd_len};
      cur_wr = {o_wr_cmd_addr, o_wr_cmd_len};
      if (i_rst) begin
        pend_rd = 1'b0;
        pend_wr = 1'b0;
      end else begin
        if (pend_rd) begin
          check("rd_vld_held", o_rd_cmd_vld, 1);
          check("rd_payload_stable", cur_rd, prv_rd);
        end
        if (pend_wr) begin
          check("wr_vld_held", o_wr_cmd_vld, 1);
          check("wr_payload_stable", cur_wr, prv_wr);
        end
        if (o_rd_cmd_vld && i_rd_cmd_rdy) begin
          if (exp_rd.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rd_unexpected: got leaf %0d addr 0x%0h len %0d expected none", o_rd_cmd_leaf, o_rd_cmd_addr, o_rd_cmd_len);
          end else begin
            e_rd = exp_rd.pop_front();
            check("rd_leaf", cur_rd.leaf, e_rd.leaf);
            check("rd_addr", cur_rd.addr, e_rd.addr);
            check("rd_len", cur_rd.len, e_rd.len);
          end
        end
        if (o_wr_cmd_vld && i_wr_cmd_rdy) begin
          -> wr_acc;
          if (exp_wr.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL wr_unexpected: got addr 0x%0h len %0d expected none", o_wr_cmd_addr, o_wr_cmd_len);
          end else begin
            e_wr = exp_wr.pop_front();
            check("wr_addr", cur_wr.addr, e_wr.addr);
            check("wr_len", cur_wr.len, e_wr.len);
          end
        end
        if (o_done) begin
          if (exp_dn.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL done_unexpected: got done expected none at %0t", $time);
          end else begin
            e_dn = exp_dn.pop_front();
            check("done_result_base", o_result_base, e_dn.base);
            check("done_pass_cnt", o_pass_cnt, e_dn.pass);
          end
        end
        pend_rd = o_rd_cmd_vld && !i_rd_cmd_rdy;
        pend_wr = o_wr_cmd_vld && !i_wr_cmd_rdy;
        prv_rd = cur_rd;
        prv_wr = cur_wr;
      end
    end
  end

  // Read-command sink: holds rdy low stall_cyc cycles per command.
  initial begin : rd_sink
    int cnt;
    cnt = 0;
    i_rd_cmd_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (o_rd_cmd_vld && cnt >= stall_cyc) begin i_rd_cmd_rdy = 1'b1; cnt = 0; end
      else if (o_rd_cmd_vld) begin i_rd_cmd_rdy = 1'b0; cnt++; end
      else begin i_rd_cmd_rdy = 1'b0; cnt = 0; end
    end
  end

  // Write-command sink, same stall policy.
  initial begin : wr_sink
    int cnt;
    cnt = 0;
    i_wr_cmd_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (o_wr_cmd_vld && cnt >= stall_cyc) begin i_wr_cmd_rdy = 1'b1; cnt = 0; end
      else if (o_wr_cmd_vld) begin i_wr_cmd_rdy = 1'b0; cnt++; end
      else begin i_wr_cmd_rdy = 1'b0; cnt = 0; end
    end
  end

  // Root model: last bundle consumed three cycles after each accepted write.
  initial begin : root_model
    root_a = 1'b0;
    forever begin
      @(wr_acc);
      repeat (3) @(posedge clk);
      #1 root_a = 1'b1;
      @(posedge clk);
      #1 root_a = 1'b0;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic start_job(input logic [63:0] src, input logic [63:0] dst,
                           input logic [31:0] total, input logic [31:0] run, output int lat);
    i_src_base = src; i_dst_base = dst; i_total_len = total; i_init_run_len = run;
    i_start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      i_start = 1'b0;
      if (o_rd_cmd_vld || o_done) begin lat = k; break; end
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!o_done && k < 3000) begin @(posedge clk); #1; k++; end
    n_vec++;
    if (!o_done) begin
      n_err++;
      $display("FAIL %s_done_timeout: got no done expected done within 3000 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_drained(input string name);
    check({name, "_rd_queue_left"}, exp_rd.size(), 0);
    check({name, "_wr_queue_left"}, exp_wr.size(), 0);
    check({name, "_done_queue_left"}, exp_dn.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rd_vld"}, o_rd_cmd_vld, 0);
    check({name, "_rd_addr"}, o_rd_cmd_addr, 0);
    check({name, "_wr_vld"}, o_wr_cmd_vld, 0);
    check({name, "_wr_len"}, o_wr_cmd_len, 0);
    check({name, "_busy"}, o_busy, 0);
    check({name, "_done"}, o_done, 0);
    check({name, "_result_base"}, o_result_base, 0);
    check({name, "_pass_cnt"}, o_pass_cnt, 0);
  endtask

  initial begin : main
    int lat;
    int k;
    i_rst = 1'b1; i_start = 1'b0; root_b = 1'b0;
    i_src_base = 64'h0; i_dst_base = 64'h0; i_total_len = 32'd0; i_init_run_len = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    i_rst = 1'b0;
    @(posedge clk); #1;

    // T1: one group of four full runs, single pass
    push_rd(2'd0, 64'h0, 32'd16);    push_rd(2'd1, 64'h800, 32'd16);
    push_rd(2'd2, 64'h1000, 32'd16); push_rd(2'd3, 64'h1800, 32'd16);
    push_wr(64'h10000, 32'd64);
    push_dn(64'h10000, 8'd1);
    start_job(64'h0, 64'h10000, 32'd64, 32'd16, lat);
    check("t1_first_vld_latency", lat, 2);
    check("t1_busy", o_busy, 1);
    wait_done("t1");
    check("t1_busy_after_done", o_busy, 0);
    check_drained("t1");

    // T2: short tail run and empty fourth leaf
    push_rd(2'd0, 64'h20000, 32'd16); push_rd(2'd1, 64'h20800, 32'd16);
    push_rd(2'd2, 64'h21000, 32'd8);  push_rd(2'd3, 64'h21400, 32'd0);
    push_wr(64'h40000, 32'd40);
    push_dn(64'h40000, 8'd1);
    start_job(64'h20000, 64'h40000, 32'd40, 32'd16, lat);
    wait_done("t2");
    check_drained("t2");

    // T3: two passes, four groups then one
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 4; i++) push_rd(i[1:0], 64'(g * 32'h2000 + i * 32'h800), 32'd16);
      push_wr(64'(32'h100000 + g * 32'h2000), 32'd64);
    end
    for (int i = 0; i < 4; i++) push_rd(i[1:0], 64'(32'h100000 + i * 32'h2000), 32'd64);
    push_wr(64'h0, 32'd256);
    push_dn(64'h0, 8'd2);
    start_job(64'h0, 64'h100000, 32'd256, 32'd16, lat);
    wait_done("t3");
    check_drained("t3");

    // T4: already a single run; done two cycles after start
    push_dn(64'h5000, 8'd0);
    start_job(64'h5000, 64'h9000, 32'd16, 32'd16, lat);
    check("t4_done_latency", lat, 2);
    wait_done("t4");
    check_drained("t4");

    // T4b: empty job
    push_dn(64'h7000, 8'd0);
    start_job(64'h7000, 64'h9000, 32'd0, 32'd4, lat);
    check("t4b_done_latency", lat, 2);
    wait_done("t4b");
    check_drained("t4b");

    // T5: backpressure on both command channels plus a stray root_last
    stall_cyc = 5;
    push_rd(2'd0, 64'h1000, 32'd16); push_rd(2'd1, 64'h1800, 32'd16);
    push_rd(2'd2, 64'h2000, 32'd8);  push_rd(2'd3, 64'h2400, 32'd0);
    push_wr(64'h80000, 32'd40);
    push_dn(64'h80000, 8'd1);
    start_job(64'h1000, 64'h80000, 32'd40, 32'd16, lat);
    check("t5_first_vld_latency", lat, 2);
    root_b = 1'b1;
    @(posedge clk); #1;
    root_b = 1'b0;
    wait_done("t5");
    check_drained("t5");
    stall_cyc = 0;

    // T6: reset while waiting for the root, then a fresh job
    push_rd(2'd0, 64'h0, 32'd16);    push_rd(2'd1, 64'h800, 32'd16);
    push_rd(2'd2, 64'h1000, 32'd16); push_rd(2'd3, 64'h1800, 32'd16);
    push_wr(64'h10000, 32'd64);
    start_job(64'h0, 64'h10000, 32'd64, 32'd16, lat);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (o_wr_cmd_vld && i_wr_cmd_rdy) break;
      k++;
    end
    n_vec++;
    if (k >= 200) begin
      n_err++;
      $display("FAIL t6_wr_timeout: got no write handshake expected one within 200 cycles");
    end
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("t6_reset");
    i_rst = 1'b0;
    check_drained("t6_abort");
    push_rd(2'd0, 64'h3000, 32'd16); push_rd(2'd1, 64'h3800, 32'd16);
    push_rd(2'd2, 64'h4000, 32'd16); push_rd(2'd3, 64'h4800, 32'd16);
    push_wr(64'h50000, 32'd64);
    push_dn(64'h50000, 8'd1);
    start_job(64'h3000, 64'h50000, 32'd64, 32'd16, lat);
    check("t6_restart_latency", lat, 2);
    wait_done("t6");
    check_drained("t6");

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
